// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and FSM state type for the multi-cycle ALU
// and the alu_control decoder.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_MULTU = 4'b1000;
  localparam logic [3:0] ALU_DIVU  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == ALU_MULTU) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one
// 2*WIDTH accumulator; go loads operands, last flags the final iteration.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             step,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] lo_next,
  output logic [WIDTH-1:0] hi_next
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   operand_b;
  logic               div_q;
  logic [CW-1:0]      count;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               fits;

  // Upper half is partial product / partial remainder; lower half shifts out
  // multiplier bits or shifts in quotient bits.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand_b} : '0);
    trial    = acc[2*WIDTH-1:WIDTH-1];
    diff     = trial - {1'b0, operand_b};
    fits     = trial >= {1'b0, operand_b};
    acc_next = acc;
    if (div_q) begin
      if (fits) acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else      acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      operand_b <= '0;
      div_q     <= 1'b0;
      count     <= '0;
    end else if (go) begin
      acc       <= {{WIDTH{1'b0}}, a};
      operand_b <= b;
      div_q     <= op_div;
      count     <= CW'(WIDTH - 1);
    end else if (step) begin
      acc <= acc_next;
      if (count != '0) count <= count - 1'b1;
    end
  end

  assign last    = (count == '0);
  assign lo_next = acc_next[WIDTH-1:0];
  assign hi_next = acc_next[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative MULTU/DIVU
// behind a start/ready/done handshake.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_by_zero
);

  state_t           state;
  logic             div_q;
  logic             bz_q;
  logic             accept;
  logic             go;
  logic             last;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] lo_next;
  logic [WIDTH-1:0] hi_next;

  assign ready  = (state != ST_CALC);
  assign done   = (state == ST_DONE);
  assign accept = start && ready;
  assign go     = accept && is_multicycle(alu_control);

  always_comb begin
    alu_y = '0;
    case (alu_control)
      ALU_AND: alu_y = A & B;
      ALU_OR:  alu_y = A | B;
      ALU_ADD: alu_y = A + B;
      ALU_SUB: alu_y = A - B;
      ALU_SLT: alu_y = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_NOR: alu_y = ~(A | B);
      default: alu_y = '0;
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (go),
    .step    (state == ST_CALC),
    .op_div  (alu_control == ALU_DIVU),
    .a       (A),
    .b       (B),
    .last    (last),
    .lo_next (lo_next),
    .hi_next (hi_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      result      <= '0;
      result_hi   <= '0;
      zero        <= 1'b1;
      div_by_zero <= 1'b0;
      div_q       <= 1'b0;
      bz_q        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_multicycle(alu_control)) begin
              state <= ST_CALC;
              div_q <= (alu_control == ALU_DIVU);
              bz_q  <= (B == '0);
            end else begin
              state       <= ST_DONE;
              result      <= alu_y;
              result_hi   <= '0;
              zero        <= (alu_y == '0);
              div_by_zero <= 1'b0;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          // Capture the final iteration's value on the same edge it is computed.
          if (last) begin
            state       <= ST_DONE;
            result      <= lo_next;
            result_hi   <= hi_next;
            zero        <= (lo_next == '0);
            div_by_zero <= div_q && bz_q;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu at WIDTH=32 and WIDTH=8 against an
// arithmetic reference model with a per-cycle scoreboard.
module tb_multicycle_alu;

  typedef struct {
    logic [63:0] lo;
    logic [63:0] hi;
    logic        z;
    logic        dbz;
    int          lat;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        chk_en = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic        start32 = 1'b0;
  logic [3:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        ready32, done32, zero32, dbz32;
  logic [31:0] res32, hi32;

  logic        start8 = 1'b0;
  logic [3:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ready8, done8, zero8, dbz8;
  logic [7:0]  res8, hi8;

  exp_t q32[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multicycle_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .alu_control(op32), .A(a32), .B(b32),
    .ready(ready32), .done(done32), .result(res32), .result_hi(hi32),
    .zero(zero32), .div_by_zero(dbz32)
  );

  multicycle_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .alu_control(op8), .A(a8), .B(b8),
    .ready(ready8), .done(done8), .result(res8), .result_hi(hi8),
    .zero(zero8), .div_by_zero(dbz8)
  );

  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input logic [63:0] a_in, input logic [63:0] b_in);
    exp_t        e;
    logic [63:0] mask, a, b;
    logic [127:0] p;
    mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a     = a_in & mask;
    b     = b_in & mask;
    e.lo  = '0;
    e.hi  = '0;
    e.dbz = 1'b0;
    e.lat = 1;
    e.due = 0;
    case (op)
      4'b0000: e.lo = a & b;
      4'b0001: e.lo = a | b;
      4'b0010: e.lo = (a + b) & mask;
      4'b0110: e.lo = (a - b) & mask;
      4'b0111: e.lo = ($signed(a << (64 - w)) < $signed(b << (64 - w))) ? 64'd1 : 64'd0;
      4'b1100: e.lo = ~(a | b) & mask;
      4'b1000: begin
        p     = {64'd0, a} * {64'd0, b};
        e.lo  = p[63:0] & mask;
        e.hi  = (p >> w) & {64'd0, mask};
        e.lat = w + 1;
      end
      4'b1001: begin
        if (b == 0) begin
          e.lo  = mask;
          e.hi  = a;
          e.dbz = 1'b1;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
        e.lat = w + 1;
      end
      default: e.lo = '0;
    endcase
    e.z = (e.lo == 0);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic score(input int d, input logic dn, input logic [63:0] lo, input logic [63:0] hi,
                       input logic z, input logic dbz);
    exp_t e;
    int   n;
    string tag;
    tag = (d == 0) ? "w32" : "w8";
    n   = (d == 0) ? q32.size() : q8.size();
    if (dn) begin
      if (n == 0) begin
        check({tag, "_spurious_done"}, 64'd1, 64'd0);
      end else begin
        e = (d == 0) ? q32.pop_front() : q8.pop_front();
        check({tag, "_latency"}, 64'(cyc), 64'(e.due));
        check({tag, "_result"}, lo, e.lo);
        check({tag, "_result_hi"}, hi, e.hi);
        check({tag, "_zero"}, {63'd0, z}, {63'd0, e.z});
        check({tag, "_div_by_zero"}, {63'd0, dbz}, {63'd0, e.dbz});
      end
    end else if (n > 0) begin
      e = (d == 0) ? q32[0] : q8[0];
      if (cyc >= e.due) begin
        check({tag, "_done_timeout"}, 64'(cyc), 64'(e.due));
        if (d == 0) void'(q32.pop_front());
        else        void'(q8.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      score(0, done32, {32'd0, res32}, {32'd0, hi32}, zero32, dbz32);
      score(1, done8, {56'd0, res8}, {56'd0, hi8}, zero8, dbz8);
    end
  end

  task automatic issue(input int d, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    int   n = 0;
    while (!((d == 0) ? ready32 : ready8) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_wait_timeout", 64'd0, 64'd1);
    e     = model((d == 0) ? 32 : 8, op, a, b);
    e.due = cyc + e.lat;
    if (d == 0) begin
      start32 = 1'b1; op32 = op; a32 = a[31:0]; b32 = b[31:0];
      q32.push_back(e);
    end else begin
      start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
      q8.push_back(e);
    end
    @(negedge clk);
    if (d == 0) start32 = 1'b0;
    else        start8  = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int n = 0;
    while (!((d == 0) ? done32 : done8) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("wait_done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run(input int d, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    issue(d, op, a, b);
    wait_done(d);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, ready32}, 64'd1);
    check("rst_done", {63'd0, done32}, 64'd0);
    check("rst_result", {32'd0, res32}, 64'd0);
    check("rst_result_hi", {32'd0, hi32}, 64'd0);
    check("rst_zero", {63'd0, zero32}, 64'd1);
    check("rst_dbz", {63'd0, dbz32}, 64'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    issue(0, 4'b0010, 64'hFFFFFFFF, 64'h1);
    check("add_done_next_cycle", {63'd0, done32}, 64'd1);
    check("add_wrap_result", {32'd0, res32}, 64'd0);
    check("add_wrap_zero", {63'd0, zero32}, 64'd1);
    check("add_wrap_hi", {32'd0, hi32}, 64'd0);
    run(0, 4'b0110, 64'd5, 64'd5);
    check("sub_zero", {63'd0, zero32}, 64'd1);
    run(0, 4'b0111, 64'hFFFFFFFF, 64'h1);
    check("slt_neg_lt_pos", {32'd0, res32}, 64'd1);
    run(0, 4'b0111, 64'h1, 64'hFFFFFFFF);
    check("slt_pos_lt_neg", {32'd0, res32}, 64'd0);
    run(0, 4'b0010, 64'd2, 64'd3);
    run(0, 4'b1111, 64'd9, 64'd9);
    check("illegal_result", {32'd0, res32}, 64'd0);
    check("illegal_zero", {63'd0, zero32}, 64'd1);

    // MULTU with a start pulse during CALC that must be dropped
    issue(0, 4'b1000, 64'hFFFFFFFF, 64'hFFFFFFFF);
    repeat (3) @(negedge clk);
    start32 = 1'b1; op32 = 4'b0010; a32 = 32'd1; b32 = 32'd1;
    @(negedge clk);
    start32 = 1'b0;
    wait_done(0);
    check("multu_hi", {32'd0, hi32}, 64'hFFFFFFFE);
    check("multu_lo", {32'd0, res32}, 64'h1);
    repeat (4) @(negedge clk);

    run(0, 4'b1001, 64'd100, 64'd7);
    check("divu_q", {32'd0, res32}, 64'd14);
    check("divu_r", {32'd0, hi32}, 64'd2);
    check("divu_dbz", {63'd0, dbz32}, 64'd0);
    run(0, 4'b1001, 64'd1234, 64'd0);
    check("div0_q", {32'd0, res32}, 64'hFFFFFFFF);
    check("div0_r", {32'd0, hi32}, 64'd1234);
    check("div0_flag", {63'd0, dbz32}, 64'd1);
    run(0, 4'b0010, 64'd3, 64'd4);
    check("add_clears_dbz", {63'd0, dbz32}, 64'd0);
    check("add_after_div0", {32'd0, res32}, 64'd7);

    run(0, 4'b0000, 64'hF0F0_1234, 64'h0FF0_FF00);
    run(0, 4'b0001, 64'hF000_0001, 64'h0000_1000);
    run(0, 4'b1100, 64'h0F0F_0F0F, 64'h0000_00F0);
    run(0, 4'b0111, 64'h8000_0000, 64'h7FFF_FFFF);
    run(0, 4'b1000, 64'h0001_2345, 64'h0000_6789);
    run(0, 4'b1001, 64'hFFFF_FFFF, 64'h0000_0010);
    run(0, 4'b1001, 64'h0000_0003, 64'h0000_0009);

    // Abort an in-flight MULTU with a one-cycle reset
    run(0, 4'b0010, 64'd3, 64'd0);
    issue(0, 4'b1000, 64'd3, 64'd5);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    q32.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_ready", {63'd0, ready32}, 64'd1);
    check("abort_result", {32'd0, res32}, 64'd0);
    check("abort_zero", {63'd0, zero32}, 64'd1);
    check("abort_done", {63'd0, done32}, 64'd0);
    repeat (45) @(negedge clk);

    run(1, 4'b1000, 64'hFF, 64'hFF);
    check("w8_multu_hi", {56'd0, hi8}, 64'hFE);
    check("w8_multu_lo", {56'd0, res8}, 64'h01);
    issue(1, 4'b0010, 64'd3, 64'd4);
    check("w8_b2b_first_done", {63'd0, done8}, 64'd1);
    issue(1, 4'b0010, 64'd10, 64'd20);
    check("w8_b2b_second_done", {63'd0, done8}, 64'd1);
    check("w8_b2b_second_result", {56'd0, res8}, 64'd30);
    run(1, 4'b0010, 64'hF0, 64'h20);
    run(1, 4'b0111, 64'h80, 64'h01);
    run(1, 4'b1001, 64'hC8, 64'h0D);
    run(1, 4'b1001, 64'h5A, 64'h00);

    repeat (45) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
